// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Holds the FSM state encoding, the mul/div aluop codes, the rstatus register index and the default exception codes.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [4:0]  ALUOP_MUL        = 5'b00110;
    localparam logic [4:0]  ALUOP_DIV        = 5'b00111;
    localparam logic [4:0]  RSTATUS_REG      = 5'd30;
    localparam logic [31:0] DEF_MUL_EXC_CODE = 32'd4;
    localparam logic [31:0] DEF_DIV_EXC_CODE = 32'd5;

    // Decode helper for the X stage: an R-type aluop that belongs to this unit.
    function automatic logic is_multdiv_aluop(input logic [4:0] aluop);
        return (aluop == ALUOP_MUL) || (aluop == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// Purpose: counts BUSY cycles and flags when the wait budget is spent.
// Latency: terminal is combinational from the registered count; clear/enable act on the next edge.
// Backpressure: none; the counter simply holds its value when it is not enabled.
module multdiv_sequencer_timeout_counter #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Purpose: sequences the shared iterative mul/div unit and retires one result or rstatus exception per op.
// Latency: start pulse 1 cycle after issue, writeback 1 cycle after unit_ready (1 cycle for divide-by-zero, 42 on timeout).
// Backpressure: stall holds F/D/X from issue until the writeback cycle; abort drops stall at once.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int          TIMEOUT      = 40,
    parameter logic [31:0] MUL_EXC_CODE = DEF_MUL_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE = DEF_DIV_EXC_CODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_op,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        abort,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] unit_result,
    input  logic        unit_exc,
    input  logic        unit_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    state_t      state_q, state_d;
    logic        op_q;
    logic [31:0] a_q, b_q, result_q;
    logic [4:0]  rd_q;
    logic        exc_q, to_q;

    logic accept, capture, force_exc;
    logic cnt_clear, cnt_enable, cnt_terminal;

    multdiv_sequencer_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        wb_valid   = 1'b0;
        timeout    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        force_exc  = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = issue_valid;
                if (issue_valid) begin
                    accept  = 1'b1;
                    state_d = (issue_op && (issue_b == '0)) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                stall     = 1'b1;
                ctrl_mult = ~op_q;
                ctrl_div  = op_q;
                cnt_clear = 1'b1;
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                stall      = 1'b1;
                cnt_enable = 1'b1;
                if (unit_ready) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_terminal) begin
                    force_exc = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_valid = 1'b1;
                timeout  = to_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // abort overrides every event, including acceptance of a new op in IDLE
        if (abort) begin
            state_d    = ST_IDLE;
            stall      = 1'b0;
            ctrl_mult  = 1'b0;
            ctrl_div   = 1'b0;
            wb_valid   = 1'b0;
            timeout    = 1'b0;
            accept     = 1'b0;
            capture    = 1'b0;
            force_exc  = 1'b0;
            cnt_clear  = 1'b0;
            cnt_enable = 1'b0;
        end
        if (!reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            to_q     <= 1'b0;
        end else if (accept) begin
            op_q  <= issue_op;
            a_q   <= issue_a;
            b_q   <= issue_b;
            rd_q  <= issue_rd;
            exc_q <= issue_op && (issue_b == '0);
            to_q  <= 1'b0;
        end else if (capture) begin
            result_q <= unit_result;
            exc_q    <= unit_exc;
        end else if (force_exc) begin
            exc_q <= 1'b1;
            to_q  <= 1'b1;
        end
    end

    assign unit_a  = a_q;
    assign unit_b  = b_q;
    assign wb_rd   = exc_q ? RSTATUS_REG : rd_q;
    assign wb_data = exc_q ? (op_q ? DIV_EXC_CODE : MUL_EXC_CODE) : result_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: directed scenarios plus random ops against a cycle-level expectation model.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_op = 1'b0;
    logic [31:0] issue_a = '0;
    logic [31:0] issue_b = '0;
    logic [4:0]  issue_rd = '0;
    logic        abort = 1'b0;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] unit_a, unit_b;
    logic [31:0] unit_result = '0;
    logic        unit_exc = 1'b0;
    logic        unit_ready = 1'b0;
    logic        stall, wb_valid, timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    multdiv_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_rd    (issue_rd),
        .abort       (abort),
        .ctrl_mult   (ctrl_mult),
        .ctrl_div    (ctrl_div),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_result (unit_result),
        .unit_exc    (unit_exc),
        .unit_ready  (unit_ready),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".ctrl_mult"}, 32'(ctrl_mult), 32'd0);
        chk({tag, ".ctrl_div"}, 32'(ctrl_div), 32'd0);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
        chk({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, ".wb_data"}, wb_data, 32'd0);
        chk({tag, ".unit_a"}, unit_a, 32'd0);
        chk({tag, ".unit_b"}, unit_b, 32'd0);
    endtask

    // One op from issue to retirement. lat = cycle (relative to issue) at which the
    // unit model raises unit_ready; 0 means the unit never answers.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input logic inj);
        int          exp_wb;
        logic        exp_exc, exp_to, divzero;
        logic [31:0] res, exp_data;
        logic [4:0]  exp_rd;
        divzero = op && (b == 32'd0);
        res     = op ? (divzero ? 32'd0 : a / b) : a * b;
        if (divzero) begin
            exp_wb = 1; exp_exc = 1'b1; exp_to = 1'b0;
        end else if (lat >= 2 && lat <= 41) begin
            exp_wb = lat + 1; exp_exc = inj; exp_to = 1'b0;
        end else begin
            exp_wb = 42; exp_exc = 1'b1; exp_to = 1'b1;
        end
        exp_rd   = exp_exc ? 5'd30 : rd;
        exp_data = exp_exc ? (op ? 32'd5 : 32'd4) : res;
        for (int c = 0; c <= exp_wb + 1; c++) begin
            issue_valid = (c <= exp_wb);
            issue_op    = op;
            issue_a     = a;
            issue_b     = b;
            issue_rd    = rd;
            unit_ready  = (c == lat);
            unit_exc    = (c == lat) && inj;
            unit_result = (c == lat) ? res : $urandom;
            #2;
            chk("stall", 32'(stall), 32'(c < exp_wb));
            chk("ctrl_mult", 32'(ctrl_mult), 32'(c == 1 && !divzero && !op));
            chk("ctrl_div", 32'(ctrl_div), 32'(c == 1 && !divzero && op));
            chk("wb_valid", 32'(wb_valid), 32'(c == exp_wb));
            chk("timeout", 32'(timeout), 32'(c == exp_wb && exp_to));
            if (c == 1) begin
                chk("unit_a", unit_a, a);
                chk("unit_b", unit_b, b);
            end
            if (c == exp_wb) begin
                chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
                chk("wb_data", wb_data, exp_data);
            end
            @(posedge clock); #1;
        end
        issue_valid = 1'b0;
        unit_ready  = 1'b0;
        unit_exc    = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        chk_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // directed scenarios
        run_op(1'b0, 32'd7, 32'd6, 5'd5, 17, 1'b0);
        run_op(1'b1, 32'd100, 32'd0, 5'd3, 0, 1'b0);
        run_op(1'b0, 32'h4000_0000, 32'd4, 5'd8, 10, 1'b1);
        run_op(1'b1, 32'd9, 32'd3, 5'd12, 0, 1'b0);
        run_op(1'b0, 32'd5, 32'd5, 5'd1, 41, 1'b0);
        run_op(1'b0, 32'd5, 32'd5, 5'd1, 42, 1'b0);
        run_op(1'b1, 32'd50, 32'd7, 5'd2, 1, 1'b0);

        // abort mid-op, stale completion, abort beats a fresh issue
        issue_op = 1'b0; issue_a = 32'd3; issue_b = 32'd5; issue_rd = 5'd7;
        for (int c = 0; c < 5; c++) begin
            issue_valid = 1'b1;
            #2;
            if (c == 1) chk("abort.ctrl_mult", 32'(ctrl_mult), 32'd1);
            @(posedge clock); #1;
        end
        abort = 1'b1;
        #2;
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clock); #1;
        abort = 1'b0; issue_valid = 1'b0;
        unit_ready = 1'b1; unit_exc = 1'b1; unit_result = 32'd15;
        #2;
        chk("stale.wb_valid", 32'(wb_valid), 32'd0);
        chk("stale.stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        unit_ready = 1'b0; unit_exc = 1'b0;
        issue_valid = 1'b1; issue_op = 1'b1; abort = 1'b1;
        #2;
        chk("abort_issue.stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        issue_valid = 1'b0; abort = 1'b0;
        #2;
        chk("abort_issue.ctrl_div", 32'(ctrl_div), 32'd0);
        chk("abort_issue.wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clock); #1;
        run_op(1'b1, 32'd8, 32'd2, 5'd9, 6, 1'b0);

        // reset asserted mid-op
        issue_op = 1'b0; issue_a = 32'd11; issue_b = 32'd13; issue_rd = 5'd4;
        for (int c = 0; c < 5; c++) begin
            issue_valid = 1'b1;
            #2;
            @(posedge clock); #1;
        end
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clock); #1;
        chk_all_zero("midreset_hold");
        reset = 1'b1; issue_valid = 1'b0;
        @(posedge clock); #1;
        run_op(1'b0, 32'd2, 32'd3, 5'd6, 4, 1'b0);

        // random ops
        for (int n = 0; n < 16; n++) begin
            logic        rop, rinj;
            logic [31:0] ra, rb;
            logic [4:0]  rrd;
            int          rlat;
            rop  = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
            rrd  = 5'($urandom_range(0, 31));
            rlat = $urandom_range(0, 44);
            rinj = ($urandom_range(0, 3) == 0);
            run_op(rop, ra, rb, rrd, rlat, rinj);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
